wt_dcache_rd_arb: RTL and testbench
===================================

Name: wt_dcache_rd_arb

Overview:
- Scheduler for the single read/word-write port of the write-through L1 dcache data/tag SRAMs.
- Arbitrates NumPorts read requesters (load unit, PTW, checkpoint port, write buffer) plus the write buffer's single-word write.
- Yields unconditionally to cacheline refills/invalidations from the miss unit.
- Provides starvation protection for low-priority requesters and a registered response tag so read data returns to the correct port.

Parameters:
NumPorts, 4, number of read requesters
IdxWidth, DCACHE_CL_IDX_WIDTH, set index width
OffWidth, DCACHE_OFFSET_WIDTH, line offset width
TagWidth, DCACHE_TAG_WIDTH, tag width
StarveLimit, 8, consecutive denied cycles before the low class is forced (≥1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rd_prio_i  in  NumPorts  1 = high-priority port (static)
rd_req_i  in  NumPorts  read request per port
rd_tag_only_i  in  NumPorts  tag-only lookup
rd_tag_i  in  NumPorts*TagWidth  compare tag
rd_idx_i  in  NumPorts*IdxWidth  set index
rd_off_i  in  NumPorts*OffWidth  offset
rd_ack_o  out  NumPorts  one-hot grant, same cycle
wr_req_i  in  1  single-word write request
wr_idx_i  in  IdxWidth  write index
wr_off_i  in  OffWidth  write offset
wr_ack_o  out  1  word write grant, same cycle
wr_cl_vld_i  in  1  refill/invalidate owns SRAM this cycle
sram_en_o  out  1  SRAM access issued
sram_we_o  out  1  access is word write
sram_tag_only_o  out  1  granted read is tag-only
sram_tag_o  out  TagWidth  muxed tag
sram_idx_o  out  IdxWidth  muxed index
sram_off_o  out  OffWidth  muxed offset
rsp_vld_o  out  1  read result valid (registered)
rsp_port_o  out  $clog2(NumPorts)  port owning result
rsp_tag_only_o  out  1  result is tag-only
perf_conflict_o  out  32  denied-request cycle count (see Optional Feature)

Behaviour:
- Reset: rd_ack_o=0, wr_ack_o=0, sram_* =0, rsp_vld_o=0, rsp_port_o=0, rsp_tag_only_o=0, both RR pointers=0, starve counter=0, perf_conflict_o=0.
- Classes:
  - High class = requesting ports with rd_prio_i=1.
  - Low class = requesting ports with rd_prio_i=0, plus word write as virtual index NumPorts.
- Grant order per cycle:
  - (1) wr_cl_vld_i=1: no grant; all acks 0; sram_en_o=0; starve counter unchanged.
  - (2) starve counter == StarveLimit and low class nonempty: low class wins.
  - (3) high class nonempty: high wins.
  - (4) otherwise low class.
- Within a class: round robin. Search starts at the class pointer; after a grant to index i, pointer = i+1, wrapping modulo the class size (NumPorts for high, NumPorts+1 for low).
- Acks are combinational, at most one asserted across rd_ack_o and wr_ack_o.
- Requesters must hold req and address until acked; dropping an unacked request is legal.
- sram_* reflect the granted requester in the same cycle; sram_we_o=1 only for a word-write grant; tag/tag_only are 0 for writes.
- Starve counter:
  - Resets to 0 on any low-class grant or when the low class is empty.
  - Otherwise increments on a cycle the low class is pending and denied (wr_cl_vld_i cycles excluded).
  - Saturates at StarveLimit.
- Response: a read grant in cycle N gives rsp_vld_o=1 in cycle N+1, with rsp_port_o=granted port and rsp_tag_only_o captured. A word-write grant gives rsp_vld_o=0 at N+1. Back-to-back grants produce back-to-back responses.
- Async reset mid-operation clears the pending response; a grant in the reset cycle is not honoured.

Optional Feature:
WT_DCACHE_ARB_PERF_EN:
- Defined: perf_conflict_o is a 32-bit counter that increments each cycle where at least one request (rd_req_i or wr_req_i) is asserted and not acked, including wr_cl_vld_i cycles. It saturates at 0xFFFFFFFF.
- Not defined: perf_conflict_o is tied to 0 and no counter flops are built.

Test Plan:
- Ports 0,1 high, both requesting continuously for 4 cycles -> acks alternate 0,1,0,1; rsp_vld_o=1 from cycle 2 with rsp_port_o matching the grant one cycle earlier.
- wr_cl_vld_i=1 for 3 cycles with rd_req_i=4'b0011 -> all acks 0, sram_en_o=0; port 0 acked on the first cycle after release.
- Port 0 high requesting continuously, word write pending, StarveLimit=8 -> wr_ack_o=1 exactly on cycle 9 with sram_we_o=1; port 0 acked on every other cycle.
- Low port 3 and word write both pending, no high requests -> grants alternate 3, write, 3; rsp_vld_o=0 after each write grant.
- Tag-only read on port 1 with idx=5 -> sram_idx_o=5, sram_tag_only_o=1 same cycle; rsp_tag_only_o=1, rsp_port_o=1 next cycle.
- rst_ni asserted the cycle after a grant -> rsp_vld_o=0 immediately; pointers and starve counter return to 0; with PERF_EN defined, perf_conflict_o=0.

Source files
------------

// File: rtl/wt_dcache_rd_arb.sv
// wt_dcache_rd_arb
// Scheduler for the shared read / word-write port of the write-through L1
// dcache data and tag SRAMs. NumPorts read requesters plus the write buffer's
// single-word write compete for one access per cycle; cacheline refills and
// invalidations from the miss unit (wr_cl_vld_i) always take precedence.
//
// Requesters split into a high class (rd_prio_i=1) and a low class
// (rd_prio_i=0 plus the word write at virtual index NumPorts). Each class
// is served round robin. A starvation counter forces the low class through
// after StarveLimit consecutive denied cycles.
//
// Optional feature macro: WT_DCACHE_ARB_PERF_EN
//   defined     -> perf_conflict_o counts cycles with a pending, unacked request
//   not defined -> perf_conflict_o is tied to zero and no counter is built
module wt_dcache_rd_arb #(
  parameter int unsigned NumPorts    = 4,
  parameter int unsigned IdxWidth    = 8,
  parameter int unsigned OffWidth    = 4,
  parameter int unsigned TagWidth    = 20,
  parameter int unsigned StarveLimit = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumPorts-1:0]              rd_prio_i,
  input  logic [NumPorts-1:0]              rd_req_i,
  input  logic [NumPorts-1:0]              rd_tag_only_i,
  input  logic [NumPorts*TagWidth-1:0]     rd_tag_i,
  input  logic [NumPorts*IdxWidth-1:0]     rd_idx_i,
  input  logic [NumPorts*OffWidth-1:0]     rd_off_i,
  output logic [NumPorts-1:0]              rd_ack_o,
  input  logic                             wr_req_i,
  input  logic [IdxWidth-1:0]              wr_idx_i,
  input  logic [OffWidth-1:0]              wr_off_i,
  output logic                             wr_ack_o,
  input  logic                             wr_cl_vld_i,
  output logic                             sram_en_o,
  output logic                             sram_we_o,
  output logic                             sram_tag_only_o,
  output logic [TagWidth-1:0]              sram_tag_o,
  output logic [IdxWidth-1:0]              sram_idx_o,
  output logic [OffWidth-1:0]              sram_off_o,
  output logic                             rsp_vld_o,
  output logic [$clog2(NumPorts)-1:0]      rsp_port_o,
  output logic                             rsp_tag_only_o,
  output logic [31:0]                      perf_conflict_o
);

  localparam int unsigned PortW   = $clog2(NumPorts);
  localparam int unsigned LowW    = $clog2(NumPorts + 1);
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  logic [PortW-1:0]   hi_ptr_r;
  logic [LowW-1:0]    lo_ptr_r;
  logic [StarveW-1:0] starve_r;
  logic               rsp_vld_r;
  logic [PortW-1:0]   rsp_port_r;
  logic               rsp_tag_only_r;

  logic [NumPorts-1:0] hi_req_s;
  logic [NumPorts:0]   lo_req_s;
  logic                hi_found_s;
  logic                lo_found_s;
  logic [PortW-1:0]    hi_sel_s;
  logic [LowW-1:0]     lo_sel_s;
  logic [PortW-1:0]    hi_cand_s;
  logic [LowW-1:0]     lo_cand_s;
  logic                starve_sat_s;
  logic                gnt_hi_s;
  logic                gnt_lo_s;
  logic                gnt_wr_s;
  logic                gnt_rd_s;
  logic [PortW-1:0]    gnt_port_s;

  // The word write occupies the top slot of the low-class request vector.
  assign hi_req_s     = rd_req_i & rd_prio_i;
  assign lo_req_s     = {wr_req_i, rd_req_i & ~rd_prio_i};
  assign starve_sat_s = (starve_r == StarveW'(StarveLimit));

  // Round-robin search of the high class, starting at its pointer.
  always_comb begin
    hi_found_s = 1'b0;
    hi_sel_s   = '0;
    hi_cand_s  = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      hi_cand_s  = PortW'((32'(hi_ptr_r) + k) % NumPorts);
      hi_sel_s   = (!hi_found_s && hi_req_s[hi_cand_s]) ? hi_cand_s : hi_sel_s;
      hi_found_s = hi_found_s | hi_req_s[hi_cand_s];
    end
  end

  // Round-robin search of the low class (ports plus word write).
  always_comb begin
    lo_found_s = 1'b0;
    lo_sel_s   = '0;
    lo_cand_s  = '0;
    for (int unsigned k = 0; k <= NumPorts; k++) begin
      lo_cand_s  = LowW'((32'(lo_ptr_r) + k) % (NumPorts + 1));
      lo_sel_s   = (!lo_found_s && lo_req_s[lo_cand_s]) ? lo_cand_s : lo_sel_s;
      lo_found_s = lo_found_s | lo_req_s[lo_cand_s];
    end
  end

  // Class selection: refill blocks all, then starvation, then high, then low.
  always_comb begin
    gnt_hi_s = 1'b0;
    gnt_lo_s = 1'b0;
    if (wr_cl_vld_i) begin
      gnt_hi_s = 1'b0;
      gnt_lo_s = 1'b0;
    end else if (starve_sat_s && lo_found_s) begin
      gnt_lo_s = 1'b1;
    end else if (hi_found_s) begin
      gnt_hi_s = 1'b1;
    end else if (lo_found_s) begin
      gnt_lo_s = 1'b1;
    end else begin
      gnt_hi_s = 1'b0;
      gnt_lo_s = 1'b0;
    end
  end

  assign gnt_wr_s   = gnt_lo_s && (lo_sel_s == LowW'(NumPorts));
  assign gnt_rd_s   = gnt_hi_s || (gnt_lo_s && !gnt_wr_s);
  assign gnt_port_s = gnt_hi_s ? hi_sel_s : PortW'(lo_sel_s);

  // Acks and SRAM command muxed from the granted requester.
  always_comb begin
    rd_ack_o        = '0;
    wr_ack_o        = 1'b0;
    sram_en_o       = 1'b0;
    sram_we_o       = 1'b0;
    sram_tag_only_o = 1'b0;
    sram_tag_o      = '0;
    sram_idx_o      = '0;
    sram_off_o      = '0;
    if (gnt_wr_s) begin
      wr_ack_o   = 1'b1;
      sram_en_o  = 1'b1;
      sram_we_o  = 1'b1;
      sram_idx_o = wr_idx_i;
      sram_off_o = wr_off_i;
    end else if (gnt_rd_s) begin
      rd_ack_o[gnt_port_s] = 1'b1;
      sram_en_o            = 1'b1;
      sram_tag_only_o      = rd_tag_only_i[gnt_port_s];
      sram_tag_o           = rd_tag_i[gnt_port_s*TagWidth +: TagWidth];
      sram_idx_o           = rd_idx_i[gnt_port_s*IdxWidth +: IdxWidth];
      sram_off_o           = rd_off_i[gnt_port_s*OffWidth +: OffWidth];
    end else begin
      sram_en_o = 1'b0;
    end
  end

  // Round-robin pointers and starvation counter; frozen while a refill owns the SRAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_ptr_r <= '0;
      lo_ptr_r <= '0;
      starve_r <= '0;
    end else if (!wr_cl_vld_i) begin
      if (gnt_hi_s) begin
        hi_ptr_r <= (hi_sel_s == PortW'(NumPorts - 1)) ? '0 : hi_sel_s + 1'b1;
      end else begin
        hi_ptr_r <= hi_ptr_r;
      end
      if (gnt_lo_s) begin
        lo_ptr_r <= (lo_sel_s == LowW'(NumPorts)) ? '0 : lo_sel_s + 1'b1;
      end else begin
        lo_ptr_r <= lo_ptr_r;
      end
      if (gnt_lo_s || !lo_found_s) begin
        starve_r <= '0;
      end else if (!starve_sat_s) begin
        starve_r <= starve_r + 1'b1;
      end else begin
        starve_r <= starve_r;
      end
    end else begin
      hi_ptr_r <= hi_ptr_r;
      lo_ptr_r <= lo_ptr_r;
      starve_r <= starve_r;
    end
  end

  // Response tag: remembers which port owns the read data returning next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_r      <= 1'b0;
      rsp_port_r     <= '0;
      rsp_tag_only_r <= 1'b0;
    end else begin
      rsp_vld_r <= gnt_rd_s;
      if (gnt_rd_s) begin
        rsp_port_r     <= gnt_port_s;
        rsp_tag_only_r <= rd_tag_only_i[gnt_port_s];
      end else begin
        rsp_port_r     <= rsp_port_r;
        rsp_tag_only_r <= rsp_tag_only_r;
      end
    end
  end

  assign rsp_vld_o      = rsp_vld_r;
  assign rsp_port_o     = rsp_port_r;
  assign rsp_tag_only_o = rsp_tag_only_r;

`ifdef WT_DCACHE_ARB_PERF_EN
  logic [31:0] perf_r;
  logic        denied_s;

  assign denied_s = (|(rd_req_i & ~rd_ack_o)) | (wr_req_i & ~wr_ack_o);

  // Saturating count of cycles in which some request waited.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_r <= 32'd0;
    end else if (denied_s && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_conflict_o = perf_r;
`else
  assign perf_conflict_o = 32'd0;
`endif

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Self-checking bench for wt_dcache_rd_arb: a behavioural grant model
// compared every cycle, plus hand-computed expectations along the way.
module tb_wt_dcache_rd_arb;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int OW = 4;
  localparam int TW = 20;
  localparam int SL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [N-1:0]        prio, req, tonly;
  logic [N*TW-1:0]     tag;
  logic [N*IW-1:0]     idx;
  logic [N*OW-1:0]     off;
  logic                wr_req;
  logic [IW-1:0]       wr_idx;
  logic [OW-1:0]       wr_off;
  logic                cl_vld;

  logic [N-1:0]        rd_ack;
  logic                wr_ack, sram_en, sram_we, sram_to;
  logic [TW-1:0]       sram_tag;
  logic [IW-1:0]       sram_idx;
  logic [OW-1:0]       sram_off;
  logic                rsp_vld, rsp_to;
  logic [$clog2(N)-1:0] rsp_port;
  logic [31:0]         perf;

  wt_dcache_rd_arb #(
    .NumPorts(N), .IdxWidth(IW), .OffWidth(OW), .TagWidth(TW), .StarveLimit(SL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_prio_i(prio), .rd_req_i(req), .rd_tag_only_i(tonly),
    .rd_tag_i(tag), .rd_idx_i(idx), .rd_off_i(off), .rd_ack_o(rd_ack),
    .wr_req_i(wr_req), .wr_idx_i(wr_idx), .wr_off_i(wr_off), .wr_ack_o(wr_ack),
    .wr_cl_vld_i(cl_vld),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_tag_only_o(sram_to),
    .sram_tag_o(sram_tag), .sram_idx_o(sram_idx), .sram_off_o(sram_off),
    .rsp_vld_o(rsp_vld), .rsp_port_o(rsp_port), .rsp_tag_only_o(rsp_to),
    .perf_conflict_o(perf)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_hp, m_lp, m_sc, m_rp;
  logic        m_rv, m_rt;
  logic [31:0] m_perf;
  int          exp_g;

  // Returns granted index: -1 none, 0..N-1 read port, N word write.
  function automatic int model_grant(input logic cl, input logic [N-1:0] pr,
                                     input logic [N-1:0] rq, input logic wr,
                                     input int hp, input int lp, input int sc);
    logic [N-1:0] hi;
    logic [N:0]   lo;
    hi = rq & pr;
    lo = {wr, rq & ~pr};
    if (cl) return -1;
    if ((|lo) && (sc == SL || !(|hi))) begin
      for (int k = 0; k <= N; k++) begin
        int j;
        j = (lp + k) % (N + 1);
        if (lo[j]) return j;
      end
    end
    if (|hi) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (hp + k) % N;
        if (hi[j]) return j;
      end
    end
    return -1;
  endfunction

  function automatic bit is_low(input int g, input logic [N-1:0] pr);
    if (g == N) return 1'b1;
    return !pr[g];
  endfunction

  always_comb exp_g = model_grant(cl_vld, prio, req, wr_req, m_hp, m_lp, m_sc);

  logic low_any;
  assign low_any = (|(req & ~prio)) | wr_req;

  logic [N-1:0] m_ack_now;
  always_comb begin
    m_ack_now = '0;
    if (exp_g >= 0 && exp_g < N) m_ack_now[exp_g] = 1'b1;
  end

  // Model state advance on each clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hp <= 0; m_lp <= 0; m_sc <= 0; m_rv <= 1'b0; m_rp <= 0; m_rt <= 1'b0; m_perf <= 32'd0;
    end else begin
      if (!cl_vld) begin
        if (exp_g >= 0 && is_low(exp_g, prio)) m_lp <= (exp_g + 1) % (N + 1);
        else if (exp_g >= 0) m_hp <= (exp_g + 1) % N;
        if ((exp_g >= 0 && is_low(exp_g, prio)) || !low_any) m_sc <= 0;
        else if (m_sc < SL) m_sc <= m_sc + 1;
      end
      m_rv <= (exp_g >= 0 && exp_g < N);
      if (exp_g >= 0 && exp_g < N) begin
        m_rp <= exp_g;
        m_rt <= tonly[exp_g];
      end
      if ((((req & ~m_ack_now) != '0) || (wr_req && exp_g != N)) && m_perf != 32'hFFFF_FFFF)
        m_perf <= m_perf + 32'd1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  logic [TW-1:0] e_tag;
  logic [IW-1:0] e_idx;
  logic [OW-1:0] e_off;
  logic          e_to;
  always @(negedge clk) begin
    e_tag = '0; e_idx = '0; e_off = '0; e_to = 1'b0;
    if (exp_g == N) begin
      e_idx = wr_idx; e_off = wr_off;
    end else if (exp_g >= 0) begin
      e_tag = tag[exp_g*TW +: TW];
      e_idx = idx[exp_g*IW +: IW];
      e_off = off[exp_g*OW +: OW];
      e_to  = tonly[exp_g];
    end
    chk("m_rd_ack", rd_ack, m_ack_now);
    chk("m_wr_ack", wr_ack, exp_g == N);
    chk("m_sram_en", sram_en, exp_g >= 0);
    chk("m_sram_we", sram_we, exp_g == N);
    chk("m_sram_tag_only", sram_to, e_to);
    chk("m_sram_tag", sram_tag, e_tag);
    chk("m_sram_idx", sram_idx, e_idx);
    chk("m_sram_off", sram_off, e_off);
    chk("m_rsp_vld", rsp_vld, m_rv);
    if (m_rv) begin
      chk("m_rsp_port", rsp_port, m_rp[1:0]);
      chk("m_rsp_tag_only", rsp_to, m_rt);
    end
`ifdef WT_DCACHE_ARB_PERF_EN
    chk("m_perf", perf, m_perf);
`else
    chk("m_perf", perf, 32'd0);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [3:0] t1_ack [4];
  logic [1:0] t1_rsp [4];
  logic [3:0] mx_prio [8];
  logic [3:0] mx_req  [8];
  logic       mx_wr   [8];
  logic       mx_cl   [8];

  initial begin
    t1_ack = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    t1_rsp = '{2'd0, 2'd0, 2'd1, 2'd0};
    mx_prio = '{4'b0101, 4'b0101, 4'b0000, 4'b1111, 4'b1000, 4'b1000, 4'b0010, 4'b0000};
    mx_req  = '{4'b1111, 4'b1111, 4'b0110, 4'b0000, 4'b1010, 4'b1010, 4'b0011, 4'b0000};
    mx_wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    mx_cl   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; prio = '0; req = '0; tonly = '0; wr_req = 1'b0; cl_vld = 1'b0;
    wr_idx = 8'hA5; wr_off = 4'h7;
    for (int p = 0; p < N; p++) begin
      tag[p*TW +: TW] = 20'h1_0000 + TW'(p * 20'h0111);
      idx[p*IW +: IW] = IW'(p * 4 + 1);
      off[p*OW +: OW] = OW'(p + 2);
    end

    // Reset state
    mid();
    chk("reset_rd_ack", rd_ack, 4'b0000);
    chk("reset_rsp_vld", rsp_vld, 1'b0);
    chk("reset_sram_en", sram_en, 1'b0);
    chk("reset_perf", perf, 32'd0);
    nxt();
    rst_n = 1'b1;

    // Two high ports alternate; response follows one cycle later
    prio = 4'b0011; req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk("rr_high_ack", rd_ack, t1_ack[c]);
      if (c > 0) begin
        chk("rr_high_rsp_vld", rsp_vld, 1'b1);
        chk("rr_high_rsp_port", rsp_port, t1_rsp[c]);
      end
      nxt();
    end

    // Refill owns the SRAM for three cycles
    cl_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("refill_ack", rd_ack, 4'b0000);
      chk("refill_sram_en", sram_en, 1'b0);
      nxt();
    end
    cl_vld = 1'b0;
    mid();
    chk("after_refill_ack", rd_ack, 4'b0001);
    nxt();
    req = 4'b0000;
    mid();
    nxt();

    // Starvation: write forced through on the ninth cycle
    prio = 4'b0001; req = 4'b0001; wr_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      mid();
      if (c < 9) begin
        chk("starve_port0_ack", rd_ack, 4'b0001);
        chk("starve_wr_ack_low", wr_ack, 1'b0);
      end else begin
        chk("starve_wr_ack", wr_ack, 1'b1);
        chk("starve_sram_we", sram_we, 1'b1);
        chk("starve_rd_ack_off", rd_ack, 4'b0000);
        chk("starve_sram_idx", sram_idx, 8'hA5);
      end
      nxt();
    end
    req = 4'b0000; wr_req = 1'b0;
    mid();
    chk("after_write_rsp_vld", rsp_vld, 1'b0);
    nxt();

    // Low port 3 and word write alternate
    prio = 4'b0000; req = 4'b1000; wr_req = 1'b1;
    mid();
    chk("low_rr_ack3", rd_ack, 4'b1000);
    chk("low_rr_wr0", wr_ack, 1'b0);
    nxt();
    mid();
    chk("low_rr_wr", wr_ack, 1'b1);
    chk("low_rr_rsp_port3", rsp_port, 2'd3);
    nxt();
    mid();
    chk("low_rr_ack3_again", rd_ack, 4'b1000);
    chk("low_rr_rsp_after_wr", rsp_vld, 1'b0);
    nxt();
    req = 4'b0000; wr_req = 1'b0;
    mid();
    nxt();

    // Tag-only lookup on port 1
    req = 4'b0010; tonly = 4'b0010;
    mid();
    chk("tagonly_ack", rd_ack, 4'b0010);
    chk("tagonly_idx", sram_idx, 8'd5);
    chk("tagonly_sram_to", sram_to, 1'b1);
    chk("tagonly_tag", sram_tag, 20'h1_0111);
    nxt();
    req = 4'b0000; tonly = 4'b0000;
    mid();
    chk("tagonly_rsp_vld", rsp_vld, 1'b1);
    chk("tagonly_rsp_port", rsp_port, 2'd1);
    chk("tagonly_rsp_to", rsp_to, 1'b1);
    nxt();

    // Async reset right after a grant
    prio = 4'b0011; req = 4'b0011; wr_req = 1'b1;
    mid();
    chk("prereset_ack", rd_ack, 4'b0010);
    nxt();
    rst_n = 1'b0; req = 4'b0000; wr_req = 1'b0;
    #1;
    chk("midreset_rsp_vld", rsp_vld, 1'b0);
    chk("midreset_perf", perf, 32'd0);
    mid();
    chk("midreset_ack", rd_ack, 4'b0000);
    nxt();
    rst_n = 1'b1; prio = 4'b0111; req = 4'b0111;
    mid();
    chk("postreset_ptr_ack", rd_ack, 4'b0001);
    nxt();

    // Mixed vectors, checked by the model only
    for (int v = 0; v < 8; v++) begin
      prio = mx_prio[v]; req = mx_req[v]; wr_req = mx_wr[v]; cl_vld = mx_cl[v];
      mid();
      nxt();
    end
    req = '0; wr_req = 1'b0; cl_vld = 1'b0;
    repeat (2) begin
      mid();
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
